// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the memory-access arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE
    } arb_state_e;

    localparam int NREQ_DEF = 2;
    localparam int AW_DEF   = 32;
    localparam int DW_DEF   = 32;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational winner picker: req vector (+ round-robin pointer) -> one-hot winner.
// Round-robin rotation when ARB_RR_EN is defined, lowest-index priority otherwise.
module arb_pick
    import mem_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0]         req,
`ifdef ARB_RR_EN
    input  logic [$clog2(NREQ)-1:0] ptr,
`endif
    output logic [NREQ-1:0]         win
);

`ifdef ARB_RR_EN
    int   idx;
    logic found;

    // Search starts one past the last winner and wraps around.
    always_comb begin
        win   = '0;
        idx   = 0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + 1 + i) % NREQ;
            if (!found && req[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`else
    logic found;

    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i]) begin
                win[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one AXI4-Lite master between NREQ requesters: grant, strobe, track busy, return data.
// Define ARB_RR_EN for round-robin arbitration; fixed lowest-index priority otherwise.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    we,
    input  logic [AW*NREQ-1:0] addr,
    input  logic [DW*NREQ-1:0] wdata,
    output logic [NREQ-1:0]    done,
    output logic [DW-1:0]      rdata,
    output logic [NREQ-1:0]    gnt,
    output logic               m_start_rd,
    output logic               m_start_wr,
    output logic [AW-1:0]      m_addr,
    output logic [DW-1:0]      m_wdata,
    input  logic               m_busy,
    input  logic [DW-1:0]      m_rdata
);

    arb_state_e       state;
    logic [NREQ-1:0]  win;
    logic             we_l;
    logic             sel_we;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_wdata;

`ifdef ARB_RR_EN
    localparam int PW = $clog2(NREQ);
    logic [PW-1:0] ptr;
    logic [PW-1:0] win_idx;

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win[i]) win_idx = PW'(i);
        end
    end

    arb_pick #(.NREQ(NREQ)) u_pick (
        .req (req),
        .ptr (ptr),
        .win (win)
    );
`else
    arb_pick #(.NREQ(NREQ)) u_pick (
        .req (req),
        .win (win)
    );
`endif

    // One-hot AND-OR mux of the winning requester's inputs.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            sel_we    = sel_we    | (we[i] & win[i]);
            sel_addr  = sel_addr  | (addr[AW*i +: AW]  & {AW{win[i]}});
            sel_wdata = sel_wdata | (wdata[DW*i +: DW] & {DW{win[i]}});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            done       <= '0;
            rdata      <= '0;
            gnt        <= '0;
            m_start_rd <= 1'b0;
            m_start_wr <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            we_l       <= 1'b0;
`ifdef ARB_RR_EN
            ptr        <= PW'(NREQ - 1);
`endif
        end else begin
            case (state)
                IDLE: begin
                    done  <= '0;
                    rdata <= '0;
                    if (|req) begin
                        gnt        <= win;
                        we_l       <= sel_we;
                        m_addr     <= sel_addr;
                        m_wdata    <= sel_wdata;
                        // Strobe is registered here so it is high for exactly the ISSUE cycle.
                        m_start_wr <= sel_we;
                        m_start_rd <= !sel_we;
`ifdef ARB_RR_EN
                        ptr        <= win_idx;
`endif
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    m_start_rd <= 1'b0;
                    m_start_wr <= 1'b0;
                    state      <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (m_busy) state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (!m_busy) begin
                        done  <= gnt;
                        rdata <= we_l ? '0 : m_rdata;
                        gnt   <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a hand-driven master busy/rdata model.
module tb_mem_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;

    logic               clk;
    logic               rst_n;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    we;
    logic [AW*NREQ-1:0] addr;
    logic [DW*NREQ-1:0] wdata;
    logic [NREQ-1:0]    done;
    logic [DW-1:0]      rdata;
    logic [NREQ-1:0]    gnt;
    logic               m_start_rd;
    logic               m_start_wr;
    logic [AW-1:0]      m_addr;
    logic [DW-1:0]      m_wdata;
    logic               m_busy;
    logic [DW-1:0]      m_rdata;

    int n_chk;
    int n_fail;

    mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .done       (done),
        .rdata      (rdata),
        .gnt        (gnt),
        .m_start_rd (m_start_rd),
        .m_start_wr (m_start_wr),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_busy     (m_busy),
        .m_rdata    (m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_done"},    64'(done),       64'd0);
        chk({tag, "_rdata"},   64'(rdata),      64'd0);
        chk({tag, "_gnt"},     64'(gnt),        64'd0);
        chk({tag, "_rd"},      64'(m_start_rd), 64'd0);
        chk({tag, "_wr"},      64'(m_start_wr), 64'd0);
        chk({tag, "_m_addr"},  64'(m_addr),     64'd0);
        chk({tag, "_m_wdata"}, 64'(m_wdata),    64'd0);
    endtask

    // Called on a negedge with req already set; returns on the negedge of the done cycle.
    task automatic serve(input string tag, input logic [1:0] exp_g, input logic exp_we,
                         input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                         input int busy_n, input logic [31:0] rd_val,
                         input logic drop, input logic poke);
        int waited;
        int lat;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!(m_start_rd || m_start_wr) && waited < 20);
        chk({tag, "_strobe_lat"}, 64'(waited), 64'd1);
        if (waited >= 20) return;
        chk({tag, "_gnt"},     64'(gnt),        64'(exp_g));
        chk({tag, "_wr"},      64'(m_start_wr), 64'(exp_we));
        chk({tag, "_rd"},      64'(m_start_rd), 64'(!exp_we));
        chk({tag, "_m_addr"},  64'(m_addr),     64'(exp_addr));
        chk({tag, "_m_wdata"}, 64'(m_wdata),    64'(exp_wdata));
        @(negedge clk);
        lat = 1;
        chk({tag, "_strobe_off"}, 64'({m_start_rd, m_start_wr}), 64'd0);
        m_busy = 1'b1;
        for (int i = 1; i < busy_n; i++) begin
            @(negedge clk);
            lat++;
            if (poke) begin
                addr  = ~addr;
                wdata = ~wdata;
            end
        end
        @(negedge clk);
        lat++;
        if (poke) begin
            chk({tag, "_hold_addr"},  64'(m_addr),  64'(exp_addr));
            chk({tag, "_hold_wdata"}, 64'(m_wdata), 64'(exp_wdata));
        end
        m_busy  = 1'b0;
        m_rdata = rd_val;
        @(negedge clk);
        lat++;
        chk({tag, "_done"},     64'(done),  64'(exp_g));
        chk({tag, "_rdata"},    64'(rdata), exp_we ? 64'd0 : 64'(rd_val));
        chk({tag, "_gnt_clr"},  64'(gnt),   64'd0);
        chk({tag, "_done_lat"}, 64'(lat),   64'(busy_n + 2));
        chk({tag, "_m_addr2"},  64'(m_addr), 64'(exp_addr));
        m_rdata = '0;
        if (drop) req = req & ~exp_g;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        req     = '0;
        we      = '0;
        addr    = '0;
        wdata   = '0;
        m_busy  = 1'b0;
        m_rdata = '0;
        repeat (2) @(negedge clk);
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single read from r0.
        addr[31:0] = 32'h08;
        we  = 2'b00;
        req = 2'b01;
        serve("rd0", 2'b01, 1'b0, 32'h08, 32'h0, 2, 32'h0000_1234, 1'b1, 1'b0);
        @(negedge clk);
        chk("idle_done", 64'(done),  64'd0);
        chk("idle_rdata", 64'(rdata), 64'd0);

        // Single write from r1.
        addr[63:32]  = 32'h10;
        wdata[63:32] = 32'hDEAD_BEEF;
        we  = 2'b10;
        req = 2'b10;
        serve("wr1", 2'b10, 1'b1, 32'h10, 32'hDEAD_BEEF, 1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        @(negedge clk);

        // Contention with both requesters reading.
        we    = 2'b00;
        addr  = {32'h30, 32'h20};
        wdata = {32'h0B, 32'h0A};
        req   = 2'b11;
`ifdef ARB_RR_EN
        serve("rr0", 2'b01, 1'b0, 32'h20, 32'h0A, 1, 32'h100, 1'b0, 1'b0);
        serve("rr1", 2'b10, 1'b0, 32'h30, 32'h0B, 1, 32'h101, 1'b0, 1'b0);
        serve("rr2", 2'b01, 1'b0, 32'h20, 32'h0A, 1, 32'h102, 1'b0, 1'b0);
        serve("rr3", 2'b10, 1'b0, 32'h30, 32'h0B, 1, 32'h103, 1'b0, 1'b0);
        req = 2'b00;
`else
        serve("fp0", 2'b01, 1'b0, 32'h20, 32'h0A, 1, 32'h100, 1'b0, 1'b0);
        serve("fp1", 2'b01, 1'b0, 32'h20, 32'h0A, 1, 32'h101, 1'b0, 1'b0);
        serve("fp2", 2'b01, 1'b0, 32'h20, 32'h0A, 1, 32'h102, 1'b1, 1'b0);
        serve("fp3", 2'b10, 1'b0, 32'h30, 32'h0B, 1, 32'h103, 1'b1, 1'b0);
`endif
        @(negedge clk);

        // Requester inputs change while the transaction is in flight.
        addr  = {32'h30, 32'h40};
        wdata = {32'h0B, 32'h0A};
        req   = 2'b01;
        serve("mid", 2'b01, 1'b0, 32'h40, 32'h0A, 2, 32'h55, 1'b1, 1'b1);
        addr  = {32'h30, 32'h44};
        wdata = {32'h0B, 32'h0A};
        @(negedge clk);

        // Reset asserted during WAIT_DONE, then a fresh request.
        req = 2'b01;
        @(negedge clk);
        chk("rst_pre_strobe", 64'(m_start_rd), 64'd1);
        @(negedge clk);
        m_busy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("mid_rst");
        req    = 2'b00;
        m_busy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle_done", 64'(done), 64'd0);
        chk("post_rst_idle_gnt",  64'(gnt),  64'd0);
        req = 2'b01;
        serve("post_rst", 2'b01, 1'b0, 32'h44, 32'h0A, 1, 32'h0000_CAFE, 1'b1, 1'b0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Memory-access scheduler that shares the single-cycle core's one AXI4-Lite master between NREQ requesters, such as instruction fetch and the load/store path. It sits between the requesters and `axi4_lite_master`. It picks one pending request, pulses the master's start strobe, tracks the master's busy/stall indication to completion, and returns read data with a one-cycle `done` pulse to the granted requester.

## Interface
- NREQ, 2, number of requesters (≥2)
- AW, 32, address width
- DW, 32, data width
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester request level; held until its `done`
- we  in  NREQ  per-requester write (1) / read (0)
- addr  in  AW*NREQ  flattened addresses; requester i at [AW*i +: AW]
- wdata  in  DW*NREQ  flattened write data, same packing
- done  out  NREQ  one-hot, one-cycle completion pulse
- rdata  out  DW  read data; valid while `done` is nonzero
- gnt  out  NREQ  one-hot current owner; zero in IDLE
- m_start_rd  out  1  one-cycle read start to master
- m_start_wr  out  1  one-cycle write start to master
- m_addr  out  AW  latched address of the granted request
- m_wdata  out  DW  latched write data of the granted request
- m_busy  in  1  master stall; high while a transaction is in flight
- m_rdata  in  DW  master read data; valid on the cycle `m_busy` falls

## Operation
- FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
- IDLE: if any `req` is high, pick winner g, set `gnt`=1<<g, latch `we[g]`, `addr[g]` and `wdata[g]`, then go to ISSUE. Otherwise stay in IDLE.
- ISSUE: assert `m_start_wr` if the latched `we` is 1, else `m_start_rd`, for exactly one cycle. Go to WAIT_ACK.
- WAIT_ACK: wait for `m_busy`=1, then go to WAIT_DONE. There is no timeout; the FSM hangs if `m_busy` never rises.
- WAIT_DONE: on the first cycle `m_busy`=0, pulse `done[g]` for one cycle. For reads, drive `rdata` with the `m_rdata` captured on that cycle (register it). Clear `gnt` and return to IDLE.
- Latched `m_addr`/`m_wdata` are held stable from ISSUE through WAIT_DONE. Changes on requester inputs during that window are ignored.
- Arbitration is evaluated only in IDLE. A `req` rising mid-transaction waits.
- The requester must drop `req` by the clock edge that ends its `done` cycle. A `req` still high in the following IDLE cycle is treated as a new request.
- A write's `rdata` is 0.

## Timing
- Reset values: `done`=0, `rdata`=0, `gnt`=0, `m_start_rd`=0, `m_start_wr`=0, `m_addr`=0, `m_wdata`=0. State=IDLE; RR pointer=NREQ-1, so requester 0 wins first.
- Reset mid-operation aborts immediately with no `done`. The master shares `rst_n`.
- `req` sampled high at edge 0 → `gnt` valid after edge 1 and ISSUE strobe in cycle 1.
- `m_busy` must not rise before the cycle after the strobe.
- Minimum latency from `req` to `done` is 4 cycles, with `m_busy` high for 1 cycle.
- Back-to-back: the next grant can be made in the IDLE cycle that immediately follows `done`.

## Configuration
- ARB_RR_EN defined: round-robin. Search starts at last grant + 1 mod NREQ, and the pointer updates to g on each grant.
- ARB_RR_EN undefined: fixed priority; the lowest index wins. The pointer logic is not compiled.

## Structure
- Package `mem_arb_pkg`: `arb_state_e` enum (IDLE, ISSUE, WAIT_ACK, WAIT_DONE) and default NREQ/AW/DW constants.
- Sub-module `arb_pick`: combinational picker (req vector, pointer → one-hot winner). It holds the round-robin rotate and the fixed-priority fallback, selected by ARB_RR_EN.

## Test plan
- Single read: r0 read, addr 0x08; `m_busy` high 2 cycles; `m_rdata`=0x00001234 at fall → `m_start_rd` pulses once with `m_addr`=0x08; `done`=01; `rdata`=0x00001234.
- Single write: r1 write, addr 0x10, wdata 0xDEADBEEF → `m_start_wr` pulse; `m_addr`=0x10; `m_wdata`=0xDEADBEEF; `done`=10; `rdata`=0.
- Contention, ARB_RR_EN defined: r0 and r1 both requesting continuously → grants alternate 0,1,0,1, each `done` separated by the transaction latency.
- Contention, ARB_RR_EN undefined: r0 requesting continuously, r1 requesting → r0 always granted; r1 starved until r0 drops `req`.
- Input change mid-flight: alter `addr[0]` during WAIT_DONE → `m_addr` unchanged.
- Reset: assert `rst_n`=0 during WAIT_DONE → all outputs 0 and state IDLE; after release, a fresh r0 request is served normally.
